// File: rtl/mem_arbiter.sv
// Two-port (fetch / data) arbiter for a shared single-port memory with a per-transaction timeout.
// Optional macro ARB_RR_EN: round-robin between the ports on simultaneous requests; default is data-port priority.
module mem_arbiter #(
    parameter int unsigned TIMEOUT_CYC = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_ready,
    input  logic        d_req,
    input  logic        d_wr,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_ready,
    output logic        mem_req,
    output logic        mem_wr,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        err,
    output logic        stall
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned CNT_W  = 8;
    localparam logic [CNT_W-1:0] TO_LIMIT = CNT_W'(TIMEOUT_CYC);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_IF = 2'd1,
        BUSY_D  = 2'd2,
        RESP    = 2'd3
    } state_t;

    state_t              state, state_n;
    logic                mem_req_n, mem_wr_n;
    logic [DATA_W-1:0]   mem_addr_n, mem_wdata_n;
    logic [DATA_W-1:0]   if_rdata_n, d_rdata_n;
    logic                if_ready_n, d_ready_n, err_n;
    logic [CNT_W-1:0]    cnt, cnt_n, cnt_inc;
    logic                grant_d;

`ifdef ARB_RR_EN
    logic                last_grant_d, last_grant_d_n;

    // On contention, the port that did not win last time gets the memory.
    assign grant_d = d_req & (~if_req | ~last_grant_d);
`else
    assign grant_d = d_req;
`endif

    assign cnt_inc = cnt + CNT_W'(1);
    assign stall   = (if_req & ~if_ready) | (d_req & ~d_ready);

    // Next-state and next-output logic
    always_comb begin
        state_n     = state;
        mem_req_n   = mem_req;
        mem_wr_n    = mem_wr;
        mem_addr_n  = mem_addr;
        mem_wdata_n = mem_wdata;
        if_rdata_n  = if_rdata;
        d_rdata_n   = d_rdata;
        if_ready_n  = 1'b0;
        d_ready_n   = 1'b0;
        err_n       = 1'b0;
        cnt_n       = cnt;
`ifdef ARB_RR_EN
        last_grant_d_n = last_grant_d;
`endif

        case (state)
            IDLE: begin
                if (grant_d) begin
                    state_n     = BUSY_D;
                    mem_req_n   = 1'b1;
                    mem_wr_n    = d_wr;
                    mem_addr_n  = d_addr;
                    mem_wdata_n = d_wdata;
                    cnt_n       = '0;
`ifdef ARB_RR_EN
                    last_grant_d_n = 1'b1;
`endif
                end else if (if_req) begin
                    state_n     = BUSY_IF;
                    mem_req_n   = 1'b1;
                    mem_wr_n    = 1'b0;
                    mem_addr_n  = if_addr;
                    mem_wdata_n = '0;
                    cnt_n       = '0;
`ifdef ARB_RR_EN
                    last_grant_d_n = 1'b0;
`endif
                end
            end

            BUSY_IF: begin
                if (mem_ack) begin
                    state_n    = RESP;
                    mem_req_n  = 1'b0;
                    if_rdata_n = mem_rdata;
                    if_ready_n = 1'b1;
                end else if (cnt_inc == TO_LIMIT) begin
                    state_n    = RESP;
                    mem_req_n  = 1'b0;
                    if_rdata_n = '0;
                    if_ready_n = 1'b1;
                    err_n      = 1'b1;
                end else begin
                    cnt_n = cnt_inc;
                end
            end

            BUSY_D: begin
                // Writes return zero read data.
                if (mem_ack) begin
                    state_n   = RESP;
                    mem_req_n = 1'b0;
                    mem_wr_n  = 1'b0;
                    d_rdata_n = mem_wr ? '0 : mem_rdata;
                    d_ready_n = 1'b1;
                end else if (cnt_inc == TO_LIMIT) begin
                    state_n   = RESP;
                    mem_req_n = 1'b0;
                    mem_wr_n  = 1'b0;
                    d_rdata_n = '0;
                    d_ready_n = 1'b1;
                    err_n     = 1'b1;
                end else begin
                    cnt_n = cnt_inc;
                end
            end

            RESP: begin
                state_n = IDLE;
            end

            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            mem_req   <= 1'b0;
            mem_wr    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_rdata  <= '0;
            d_rdata   <= '0;
            if_ready  <= 1'b0;
            d_ready   <= 1'b0;
            err       <= 1'b0;
            cnt       <= '0;
`ifdef ARB_RR_EN
            last_grant_d <= 1'b0;
`endif
        end else begin
            state     <= state_n;
            mem_req   <= mem_req_n;
            mem_wr    <= mem_wr_n;
            mem_addr  <= mem_addr_n;
            mem_wdata <= mem_wdata_n;
            if_rdata  <= if_rdata_n;
            d_rdata   <= d_rdata_n;
            if_ready  <= if_ready_n;
            d_ready   <= d_ready_n;
            err       <= err_n;
            cnt       <= cnt_n;
`ifdef ARB_RR_EN
            last_grant_d <= last_grant_d_n;
`endif
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter (TIMEOUT_CYC=4): fetch, write, contention, timeout, reset abort.
module tb_mem_arbiter;

    localparam int unsigned TO = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic [31:0] if_rdata;
    logic        if_ready;
    logic        d_req = 1'b0;
    logic        d_wr = 1'b0;
    logic [31:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic [31:0] d_rdata;
    logic        d_ready;
    logic        mem_req;
    logic        mem_wr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic        mem_ack = 1'b0;
    logic        err;
    logic        stall;

    int n_checks = 0;
    int n_errors = 0;
    bit first_d;

    mem_arbiter #(.TIMEOUT_CYC(TO)) dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_rdata  (if_rdata),
        .if_ready  (if_ready),
        .d_req     (d_req),
        .d_wr      (d_wr),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_rdata   (d_rdata),
        .d_ready   (d_ready),
        .mem_req   (mem_req),
        .mem_wr    (mem_wr),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .err       (err),
        .stall     (stall)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Ready pulses must never coincide.
    always @(negedge clk) begin
        if (!rst) check("ready_overlap", 32'(if_ready & d_ready), 32'd0);
    end

    initial begin
`ifdef ARB_RR_EN
        first_d = 1'b0;
`else
        first_d = 1'b1;
`endif
        step;
        step;
        check("rst_mem_req",  32'(mem_req),  32'd0);
        check("rst_if_ready", 32'(if_ready), 32'd0);
        check("rst_d_ready",  32'(d_ready),  32'd0);
        check("rst_err",      32'(err),      32'd0);
        check("rst_mem_addr", mem_addr,      32'd0);
        check("rst_if_rdata", if_rdata,      32'd0);
        rst = 1'b0;
        step;

        // Single fetch, ack two cycles after mem_req
        if_req = 1'b1; if_addr = 32'h40;
        #1 check("f_stall_hi", 32'(stall), 32'd1);
        step;
        check("f_mem_req",  32'(mem_req), 32'd1);
        check("f_mem_addr", mem_addr,     32'h40);
        check("f_mem_wr",   32'(mem_wr),  32'd0);
        step;
        check("f_wait_req",   32'(mem_req),  32'd1);
        check("f_wait_ready", 32'(if_ready), 32'd0);
        mem_ack = 1'b1; mem_rdata = 32'h2008_0005;
        step;
        check("f_if_ready", 32'(if_ready), 32'd1);
        check("f_if_rdata", if_rdata,      32'h2008_0005);
        check("f_req_low",  32'(mem_req),  32'd0);
        check("f_err",      32'(err),      32'd0);
        check("f_stall_lo", 32'(stall),    32'd0);
        mem_ack = 1'b0; if_req = 1'b0;
        step;
        check("f_ready_drop", 32'(if_ready), 32'd0);
        check("f_rdata_hold", if_rdata,      32'h2008_0005);
        check("f_stall_idle", 32'(stall),    32'd0);

        // Data write
        d_req = 1'b1; d_wr = 1'b1; d_addr = 32'h10; d_wdata = 32'hDEAD_BEEF;
        step;
        check("w_mem_req",   32'(mem_req), 32'd1);
        check("w_mem_wr",    32'(mem_wr),  32'd1);
        check("w_mem_addr",  mem_addr,     32'h10);
        check("w_mem_wdata", mem_wdata,    32'hDEAD_BEEF);
        mem_ack = 1'b1; mem_rdata = 32'h1234_5678;
        step;
        check("w_d_ready",  32'(d_ready),  32'd1);
        check("w_d_rdata",  d_rdata,       32'd0);
        check("w_if_ready", 32'(if_ready), 32'd0);
        mem_ack = 1'b0; d_req = 1'b0; d_wr = 1'b0;
        step;

        // Contention right after a data grant
        if_req = 1'b1; if_addr = 32'h80;
        d_req = 1'b1; d_wr = 1'b0; d_addr = 32'h100; d_wdata = 32'd0;
        step;
        check("a1_mem_addr", mem_addr, first_d ? 32'h100 : 32'h80);
        check("a1_mem_wr",   32'(mem_wr), 32'd0);
        mem_ack = 1'b1; mem_rdata = 32'hA1;
        step;
        check("a1_d_ready",  32'(d_ready),  32'(first_d));
        check("a1_if_ready", 32'(if_ready), 32'(!first_d));
        check("a1_rdata",    first_d ? d_rdata : if_rdata, 32'hA1);
        mem_ack = 1'b0;
        if (first_d) d_req = 1'b0;
        else         if_req = 1'b0;
        step;
        check("a_gap_req", 32'(mem_req), 32'd0);
        step;
        check("a2_mem_req",  32'(mem_req), 32'd1);
        check("a2_mem_addr", mem_addr, first_d ? 32'h80 : 32'h100);
        mem_ack = 1'b1; mem_rdata = 32'hB2;
        step;
        check("a2_d_ready",  32'(d_ready),  32'(!first_d));
        check("a2_if_ready", 32'(if_ready), 32'(first_d));
        check("a2_rdata",    first_d ? if_rdata : d_rdata, 32'hB2);
        mem_ack = 1'b0; if_req = 1'b0; d_req = 1'b0;
        step;

        // Timeout: no ack for TO busy cycles
        d_req = 1'b1; d_wr = 1'b0; d_addr = 32'h200;
        step;
        check("t_req_1", 32'(mem_req), 32'd1);
        for (int i = 2; i <= 4; i++) begin
            step;
            check("t_req_hold", 32'(mem_req), 32'd1);
            check("t_no_ready", 32'(d_ready), 32'd0);
        end
        step;
        check("t_req_drop", 32'(mem_req), 32'd0);
        check("t_d_ready",  32'(d_ready), 32'd1);
        check("t_err",      32'(err),     32'd1);
        check("t_d_rdata",  d_rdata,      32'd0);
        d_req = 1'b0;
        step;
        check("t_err_drop", 32'(err), 32'd0);
        step;

        // Ack arriving on the limit cycle wins over the timeout
        d_req = 1'b1; d_addr = 32'h204;
        step;
        step;
        step;
        step;
        mem_ack = 1'b1; mem_rdata = 32'h55;
        step;
        check("l_d_ready", 32'(d_ready), 32'd1);
        check("l_err",     32'(err),     32'd0);
        check("l_d_rdata", d_rdata,      32'h55);
        mem_ack = 1'b0; d_req = 1'b0;
        step;

        // Stray ack while idle is ignored
        mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
        step;
        step;
        check("s_if_ready", 32'(if_ready), 32'd0);
        check("s_d_ready",  32'(d_ready),  32'd0);
        check("s_mem_req",  32'(mem_req),  32'd0);
        mem_ack = 1'b0;
        step;

        // Reset during BUSY_IF aborts silently, held request is re-granted
        if_req = 1'b1; if_addr = 32'h300;
        step;
        check("r_mem_req", 32'(mem_req), 32'd1);
        rst = 1'b1;
        step;
        check("r_req_low",  32'(mem_req),  32'd0);
        check("r_no_ready", 32'(if_ready), 32'd0);
        check("r_no_err",   32'(err),      32'd0);
        rst = 1'b0;
        step;
        check("r_regrant",  32'(mem_req),  32'd1);
        check("r_addr",     mem_addr,      32'h300);
        check("r_ready_lo", 32'(if_ready), 32'd0);
        mem_ack = 1'b1; mem_rdata = 32'h77;
        step;
        check("r_if_ready", 32'(if_ready), 32'd1);
        check("r_if_rdata", if_rdata,      32'h77);
        mem_ack = 1'b0; if_req = 1'b0;
        step;
        step;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
